// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer with a valid/ready load handshake.
// Each accepted word leaves as WIDTH consecutive bits, framed by start/end
// strobes, optionally followed by GAP idle cycles. Counts completed words.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy,
    output logic [7:0]       word_cnt
);

    localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  shreg_reg, shreg_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [3:0]        gapcnt_reg, gapcnt_next;
    logic [7:0]        word_cnt_reg, word_cnt_next;
    logic [WIDTH-1:0]  shreg_shifted;

    // Shift one position toward the output end, zero-filling the far end.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (MSB_FIRST) begin : g_left
            if (gi == 0) begin : g_fill
                assign shreg_shifted[gi] = 1'b0;
            end else begin : g_move
                assign shreg_shifted[gi] = shreg_reg[gi-1];
            end
        end else begin : g_right
            if (gi == WIDTH - 1) begin : g_fill
                assign shreg_shifted[gi] = 1'b0;
            end else begin : g_move
                assign shreg_shifted[gi] = shreg_reg[gi+1];
            end
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            shreg_reg    <= '0;
            cnt_reg      <= '0;
            gapcnt_reg   <= '0;
            word_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            shreg_reg    <= shreg_next;
            cnt_reg      <= cnt_next;
            gapcnt_reg   <= gapcnt_next;
            word_cnt_reg <= word_cnt_next;
        end
    end

    // Next-state logic and Moore/handshake outputs.
    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        cnt_next      = cnt_reg;
        gapcnt_next   = gapcnt_reg;
        word_cnt_next = word_cnt_reg;
        load_ready    = 1'b0;
        dout          = 1'b0;
        dout_valid    = 1'b0;
        frame_start   = 1'b0;
        frame_end     = 1'b0;
        busy          = (state_reg != ST_IDLE);

        case (state_reg)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    shreg_next = load_data;
                    cnt_next   = '0;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                dout_valid  = 1'b1;
                dout        = MSB_FIRST ? shreg_reg[WIDTH-1] : shreg_reg[0];
                frame_start = (cnt_reg == '0);
                frame_end   = (cnt_reg == CNT_LAST);
                if (cnt_reg == CNT_LAST) begin
                    // Word complete: only a gapless configuration can chain.
                    load_ready    = (GAP == 0);
                    word_cnt_next = word_cnt_reg + 8'd1;
                    cnt_next      = '0;
                    shreg_next    = shreg_shifted;
                    if (GAP > 0) begin
                        gapcnt_next = '0;
                        state_next  = ST_GAP;
                    end else if (load_valid) begin
                        shreg_next = load_data;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    shreg_next = shreg_shifted;
                    cnt_next   = cnt_reg + 1'b1;
                end
            end
            ST_GAP: begin
                gapcnt_next = gapcnt_reg + 4'd1;
                if (gapcnt_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign word_cnt = word_cnt_reg;

endmodule
